ram_sync_arbiter: RTL
=====================

# ram_sync_arbiter

- Two-requester front end for one `ram_sync` instance.
- Arbitrates the RAM's write port and read port independently, so one write and one read can issue in the same cycle.
- Tracks read latency (1 or 2 cycles, per `OUTPUT_REG`) and routes read data back to the issuing requester.
- Sits between two pipeline clients (e.g. fetch and load/store) and a shared synchronous RAM.

## Interface
- `DATA_WIDTH`, 32: data word width; must be a multiple of 8.
- `ADDR_WIDTH`, 8: word address width.
- `OUTPUT_REG`, 0: must match the RAM's `OUTPUT_REG`; selects read latency of 1 (0) or 2 (1).

Ports (`N` in {0,1}):
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reqN_valid` in 1: request present.
- `reqN_ready` out 1: request accepted this cycle; combinational from grant.
- `reqN_we` in 1: 1 = write, 0 = read.
- `reqN_addr` in `ADDR_WIDTH`: word address.
- `reqN_wdata` in `DATA_WIDTH`: write data.
- `reqN_wstrb` in `DATA_WIDTH/8`: byte enables.
- `rspN_valid` out 1: read data valid for port N; no backpressure.
- `rspN_rdata` out `DATA_WIDTH`: read data.
- `ram_wdata` out `DATA_WIDTH`, `ram_waddr` out `ADDR_WIDTH`, `ram_wvalid` out 1, `ram_wstrb` out `DATA_WIDTH/8`: RAM write port.
- `ram_raddr` out `ADDR_WIDTH`, `ram_rvalid` out 1: RAM read port.
- `ram_rdata` in `DATA_WIDTH`: RAM read data.
- `ram_oreg_cen` out 1: RAM output-register clock enable.

## Operation
- Each cycle forms a write candidate set and a read candidate set from `reqN_valid` and `reqN_we`.
- **Write slot**
  - One candidate: it is granted.
  - Two candidates: the port not equal to `wr_last` wins.
  - `wr_last` updates to the granted port on every write grant.
- **Read slot**
  - Same rule, using `rd_last`.
- **Collision stall**
  - Applies when the chosen read and chosen write target the same address in the same cycle.
  - The read is not granted; it retries next cycle and then sees the new data.
  - `rd_last` does not update on a stall.
- **Grant outputs**
  - `reqN_ready` = granted, and is 0 whenever `reqN_valid` is 0.
  - Accept = `valid & ready`.
  - `ram_wvalid` = write grant; `ram_rvalid` = read grant. Address and data muxes select the granted port.
  - RAM outputs are don't-care when their valid is low, but must not be X.
- **Read tag pipeline**
  - Depth `1+OUTPUT_REG`; each entry holds {valid, port}.
  - Stage 0 loads on read grant.
  - With `OUTPUT_REG=1`, stage 1 loads from stage 0 every cycle, and `ram_oreg_cen` = stage-0 valid.
  - With `OUTPUT_REG=0`, `ram_oreg_cen` = 0.
- **Response routing**
  - The last tag stage drives responses: `rspN_valid` = tag valid and tag port == N.
  - `rsp0_rdata` and `rsp1_rdata` both carry `ram_rdata`.
- **Write responses**: none; writes are fire-and-forget.
- **Ordering**: a read accepted in a cycle after a write to the same address is accepted returns the new data.
- **Throughput**: up to one read and one write per cycle, sustained.

## Timing
- **Reset values**: `reqN_ready`=0, `rspN_valid`=0, `ram_wvalid`=0, `ram_rvalid`=0, `ram_oreg_cen`=0. All tag stages are invalid; `wr_last`=`rd_last`=1, so port 0 wins the first conflict.
- **Read latency**: accept in cycle T gives `rspN_valid` in cycle T+1 (`OUTPUT_REG=0`) or T+2 (`OUTPUT_REG=1`).
- **Write**: the RAM is updated at the end of the accept cycle.
- **Reset mid-operation**: in-flight read tags are discarded and no response is produced for them. The response for a read accepted in the cycle `rst` is high never appears; grants are forced to 0 while `rst`=1.
- **Simultaneous events**
  - p0 read with p1 write, different addresses: both accepted in the same cycle.
  - Both ports write the same address: the winner writes; the loser writes the next cycle, so the last writer's data persists.

## Configuration
- `RAM_SYNC_ARB_FIXED_PRIO_EN` defined: port 0 always wins both slots. `wr_last` and `rd_last` are not implemented; port 1 can starve.
- Not defined: round-robin as described above.

## Test plan
- **Concurrent issue**: p0 read @0x10 and p1 write @0x20 in the same cycle, `OUTPUT_REG=0` -> both readies=1; `rsp0_valid`=1 one cycle later with the prior contents of 0x10.
- **Write conflict, round-robin**: both write @0x05 (p0=0xAAAA_AAAA, p1=0x5555_5555), held valid -> p0 granted cycle 0, p1 cycle 1. A later read returns 0x5555_5555.
- **Read alternation**: both read continuously for 4 cycles -> grants alternate p0, p1, p0, p1. Responses arrive in the same order, each with the correct port's `rspN_valid`.
- **Collision stall**: p1 writes 0x1234_5678 @0x40 while p0 reads @0x40 -> p0 is stalled one cycle, then returns 0x1234_5678.
- **Output register**: with `OUTPUT_REG=1`, a read accepted at T gives `rsp_valid` at T+2. `ram_oreg_cen`=1 only at T+1.
- **Reset mid-flight**: read accepted at T, `rst` at T+1 -> no `rspN_valid` at T+1 or T+2; all outputs are at reset values.

Source files
------------

// File: rtl/ram_sync_arbiter.sv
// ram_sync_arbiter
//   Two-requester front end for one synchronous RAM (ram_sync). The write port
//   and the read port are arbitrated independently, so one write and one read
//   can issue in the same cycle. A small tag pipeline follows each read through
//   the RAM latency (1 cycle, or 2 with OUTPUT_REG=1) and steers the returning
//   data to the port that issued it.
//
//   Arbitration is round-robin per slot by default. Define
//   RAM_SYNC_ARB_FIXED_PRIO_EN to give port 0 absolute priority on both slots.
//   In that mode no last-winner state exists and port 1 can starve.
//
// Ports (N in {0,1}):
//   clk, rst               clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata/wstrb
//                          request from client N (we=1 write, 0 read)
//   reqN_ready             request accepted this cycle (combinational)
//   rspN_valid/rdata       read response for client N, no backpressure
//   ram_w{valid,addr,data,strb}
//                          RAM write port
//   ram_r{valid,addr}      RAM read port
//   ram_rdata              RAM read data
//   ram_oreg_cen           RAM output-register clock enable
module ram_sync_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int OUTPUT_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_we,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] req0_wstrb,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_we,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] req1_wstrb,
  output logic                    rsp0_valid,
  output logic [DATA_WIDTH-1:0]   rsp0_rdata,
  output logic                    rsp1_valid,
  output logic [DATA_WIDTH-1:0]   rsp1_rdata,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [ADDR_WIDTH-1:0]   ram_waddr,
  output logic                    ram_wvalid,
  output logic [DATA_WIDTH/8-1:0] ram_wstrb,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  output logic                    ram_rvalid,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic                    ram_oreg_cen
);

  logic wr_c0, wr_c1, rd_c0, rd_c1;
  logic wr_any, rd_any;
  logic wr_sel, rd_sel;   // 0 = port 0, 1 = port 1
  logic rd_hit;
  logic wr_gnt, rd_gnt;

`ifndef RAM_SYNC_ARB_FIXED_PRIO_EN
  logic wr_last, rd_last;
`endif

  always_comb begin
    wr_c0  = req0_valid & req0_we;
    wr_c1  = req1_valid & req1_we;
    rd_c0  = req0_valid & ~req0_we;
    rd_c1  = req1_valid & ~req1_we;
    wr_any = ~rst & (wr_c0 | wr_c1);
    rd_any = ~rst & (rd_c0 | rd_c1);
`ifdef RAM_SYNC_ARB_FIXED_PRIO_EN
    wr_sel = ~wr_c0;
    rd_sel = ~rd_c0;
`else
    // Port 1 wins when alone, or on a tie when port 0 won last time.
    wr_sel = wr_c1 & (~wr_c0 | ~wr_last);
    rd_sel = rd_c1 & (~rd_c0 | ~rd_last);
`endif
    ram_waddr = wr_sel ? req1_addr  : req0_addr;
    ram_wdata = wr_sel ? req1_wdata : req0_wdata;
    ram_wstrb = wr_sel ? req1_wstrb : req0_wstrb;
    ram_raddr = rd_sel ? req1_addr  : req0_addr;
    // A read of the word being written this cycle would see stale data, so it
    // waits one cycle and picks up the new contents.
    rd_hit     = wr_any & rd_any & (ram_raddr == ram_waddr);
    wr_gnt     = wr_any;
    rd_gnt     = rd_any & ~rd_hit;
    ram_wvalid = wr_gnt;
    ram_rvalid = rd_gnt;
    req0_ready = (wr_gnt & ~wr_sel) | (rd_gnt & ~rd_sel);
    req1_ready = (wr_gnt &  wr_sel) | (rd_gnt &  rd_sel);
  end

`ifndef RAM_SYNC_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_last <= 1'b1;
      rd_last <= 1'b1;
    end else begin
      if (wr_gnt) wr_last <= wr_sel;
      if (rd_gnt) rd_last <= rd_sel;
    end
  end
`endif

  // ---- stage p0: tag of the read issued last cycle ----
  logic tag_vld_p0, tag_port_p0;
  logic last_vld, last_port, oreg_cen_int;

  always_ff @(posedge clk) begin
    if (rst) tag_vld_p0 <= 1'b0;
    else     tag_vld_p0 <= rd_gnt;
  end

  always_ff @(posedge clk) begin
    tag_port_p0 <= rd_sel;
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      // ---- stage p1: tag aligned with the RAM output register ----
      logic tag_vld_p1, tag_port_p1;

      always_ff @(posedge clk) begin
        if (rst) tag_vld_p1 <= 1'b0;
        else     tag_vld_p1 <= tag_vld_p0;
      end

      always_ff @(posedge clk) begin
        tag_port_p1 <= tag_port_p0;
      end

      assign last_vld     = tag_vld_p1;
      assign last_port    = tag_port_p1;
      assign oreg_cen_int = tag_vld_p0;
    end else begin : g_noreg
      assign last_vld     = tag_vld_p0;
      assign last_port    = tag_port_p0;
      assign oreg_cen_int = 1'b0;
    end
  endgenerate

  // Gating with rst drops a response that would otherwise land in a reset cycle.
  always_comb begin
    ram_oreg_cen = oreg_cen_int & ~rst;
    rsp0_valid   = last_vld & ~last_port & ~rst;
    rsp1_valid   = last_vld &  last_port & ~rst;
    rsp0_rdata   = ram_rdata;
    rsp1_rdata   = ram_rdata;
  end

endmodule
